// File: rtl/sram_mem_arbiter.sv
// Fixed-priority arbiter serialising the core's fetch and data ports onto one
// 32-bit asynchronous SRAM (two 16-bit chips with per-byte enables).
// All SRAM pins and ready pulses come straight from flops. They are computed
// from the next state, so each pin changes on the same edge as its state.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no access; arbitrate data_write > data_read > inst_read
// RD       | ce/oe asserted for RD_WAIT cycles, data sampled on last edge
// WR_SETUP | address/data/byte enables driven, we_n still high
// WR_PULSE | we_n low for WR_WAIT cycles
// WR_HOLD  | we_n released, data still driven for hold time
// DONE     | ready pulse to the granted port, SRAM idle
module sram_mem_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_addr,
  input  logic                  inst_read,
  output logic [31:0]           inst,
  output logic                  inst_ready,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [3:0]            bwe,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [31:0]           sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    port_data, port_data_nxt;  // 1: data port granted, 0: fetch
  logic [3:0]              bwe_q, bwe_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [31:0]             wdata_nxt;
  logic                    capture;

  logic                    ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;
  logic [3:0]              be_n_nxt;
  logic                    inst_ready_nxt, data_ready_nxt;

  // Only the word-address slice of each byte address reaches the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0],
                              data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, arbitration, wait counter and grant latching.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    port_data_nxt = port_data;
    addr_nxt      = sram_addr;
    wdata_nxt     = sram_dq_o;
    bwe_nxt       = bwe_q;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_write) begin
          // A simultaneous data_read is dropped: the store alone answers the port.
          state_nxt     = WR_SETUP;
          cnt_nxt       = '0;
          port_data_nxt = 1'b1;
          addr_nxt      = data_addr[ADDR_WIDTH+1:2];
          wdata_nxt     = data_wdata;
          bwe_nxt       = bwe;
        end else if (data_read) begin
          state_nxt     = RD;
          cnt_nxt       = RD_LOAD;
          port_data_nxt = 1'b1;
          addr_nxt      = data_addr[ADDR_WIDTH+1:2];
          wdata_nxt     = data_wdata;
          bwe_nxt       = bwe;
        end else if (inst_read) begin
          state_nxt     = RD;
          cnt_nxt       = RD_LOAD;
          port_data_nxt = 1'b0;
          addr_nxt      = inst_addr[ADDR_WIDTH+1:2];
          wdata_nxt     = data_wdata;
          bwe_nxt       = bwe;
        end
      end
      RD: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_nxt = WR_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WR_HOLD: begin
        state_nxt = DONE;
        cnt_nxt   = '0;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pin values for the state being entered, so the output flops line up with it.
  always_comb begin
    ce_n_nxt       = 1'b1;
    oe_n_nxt       = 1'b1;
    we_n_nxt       = 1'b1;
    dq_oe_nxt      = 1'b0;
    be_n_nxt       = 4'hF;
    inst_ready_nxt = 1'b0;
    data_ready_nxt = 1'b0;
    unique case (state_nxt)
      RD: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
        be_n_nxt = 4'h0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_nxt  = 1'b0;
        dq_oe_nxt = 1'b1;
        be_n_nxt  = ~bwe_nxt;
      end
      WR_PULSE: begin
        ce_n_nxt  = 1'b0;
        we_n_nxt  = 1'b0;
        dq_oe_nxt = 1'b1;
        be_n_nxt  = ~bwe_nxt;
      end
      DONE: begin
        inst_ready_nxt = ~port_data_nxt;
        data_ready_nxt = port_data_nxt;
      end
      default: ;
    endcase
  end

  // Registered datapath, SRAM pins and ready pulses; reset forces the SRAM idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      port_data  <= 1'b0;
      bwe_q      <= 4'h0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      inst       <= '0;
      data_rdata <= '0;
    end else begin
      cnt        <= cnt_nxt;
      port_data  <= port_data_nxt;
      bwe_q      <= bwe_nxt;
      sram_addr  <= addr_nxt;
      sram_dq_o  <= wdata_nxt;
      sram_dq_oe <= dq_oe_nxt;
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_be_n  <= be_n_nxt;
      inst_ready <= inst_ready_nxt;
      data_ready <= data_ready_nxt;
      if (capture) begin
        if (port_data) data_rdata <= sram_dq_i;
        else           inst       <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Bench for sram_mem_arbiter: behavioural SRAM per DUT, vector table driven
// through a scoreboard queue, plus contention, reset-mid-write and a second
// instance with RD_WAIT=1 / WR_WAIT=3.
module tb_sram_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic        inst_read = 1'b0, data_read = 1'b0, data_write = 1'b0;
  logic [3:0]  bwe = 4'h0;
  logic        use1 = 1'b0;

  logic [31:0] u0_inst, u0_rdata, u0_dq_o, u0_dq_i;
  logic        u0_inst_ready, u0_data_ready, u0_dq_oe, u0_ce_n, u0_oe_n, u0_we_n;
  logic [17:0] u0_addr;
  logic [3:0]  u0_be_n;
  logic [31:0] u1_inst, u1_rdata, u1_dq_o, u1_dq_i;
  logic        u1_inst_ready, u1_data_ready, u1_dq_oe, u1_ce_n, u1_oe_n, u1_we_n;
  logic [17:0] u1_addr;
  logic [3:0]  u1_be_n;

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_mem_arbiter u0 (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_read(inst_read), .inst(u0_inst), .inst_ready(u0_inst_ready),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(u0_rdata),
    .data_read(data_read), .data_write(data_write), .bwe(bwe), .data_ready(u0_data_ready),
    .sram_addr(u0_addr), .sram_dq_o(u0_dq_o), .sram_dq_oe(u0_dq_oe), .sram_dq_i(u0_dq_i),
    .sram_ce_n(u0_ce_n), .sram_oe_n(u0_oe_n), .sram_we_n(u0_we_n), .sram_be_n(u0_be_n)
  );

  sram_mem_arbiter #(.ADDR_WIDTH(18), .RD_WAIT(1), .WR_WAIT(3)) u1 (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_read(inst_read), .inst(u1_inst), .inst_ready(u1_inst_ready),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(u1_rdata),
    .data_read(data_read), .data_write(data_write), .bwe(bwe), .data_ready(u1_data_ready),
    .sram_addr(u1_addr), .sram_dq_o(u1_dq_o), .sram_dq_oe(u1_dq_oe), .sram_dq_i(u1_dq_i),
    .sram_ce_n(u1_ce_n), .sram_oe_n(u1_oe_n), .sram_we_n(u1_we_n), .sram_be_n(u1_be_n)
  );

  // Asynchronous SRAM models: combinational read, byte-enabled write while we_n is low.
  assign u0_dq_i = (!u0_ce_n && !u0_oe_n) ? mem0[u0_addr[9:0]] : 32'h0;
  assign u1_dq_i = (!u1_ce_n && !u1_oe_n) ? mem1[u1_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (!u0_ce_n && !u0_we_n)
      for (int b = 0; b < 4; b++)
        if (!u0_be_n[b]) mem0[u0_addr[9:0]][8*b +: 8] <= u0_dq_o[8*b +: 8];
    if (!u1_ce_n && !u1_we_n)
      for (int b = 0; b < 4; b++)
        if (!u1_be_n[b]) mem1[u1_addr[9:0]][8*b +: 8] <= u1_dq_o[8*b +: 8];
  end

  // Observed instance.
  logic [31:0] o_inst, o_rdata, o_dq_o;
  logic        o_inst_ready, o_data_ready, o_dq_oe, o_ce_n, o_oe_n, o_we_n;
  logic [17:0] o_addr;
  logic [3:0]  o_be_n;
  assign o_inst       = use1 ? u1_inst       : u0_inst;
  assign o_rdata      = use1 ? u1_rdata      : u0_rdata;
  assign o_dq_o       = use1 ? u1_dq_o       : u0_dq_o;
  assign o_inst_ready = use1 ? u1_inst_ready : u0_inst_ready;
  assign o_data_ready = use1 ? u1_data_ready : u0_data_ready;
  assign o_dq_oe      = use1 ? u1_dq_oe      : u0_dq_oe;
  assign o_ce_n       = use1 ? u1_ce_n       : u0_ce_n;
  assign o_oe_n       = use1 ? u1_oe_n       : u0_oe_n;
  assign o_we_n       = use1 ? u1_we_n       : u0_we_n;
  assign o_addr       = use1 ? u1_addr       : u0_addr;
  assign o_be_n       = use1 ? u1_be_n       : u0_be_n;

  // kind: 0 fetch, 1 load, 2 store, 3 load+store together
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bwe;
    logic [31:0] data;   // expected inst / data_rdata after a read
    logic [31:0] hold;   // expected data_rdata after a fetch or store
    logic [17:0] saddr;
    int          lat;
    int          wec;
    int          oec;
    logic        hchk;
  } vec_t;

  typedef struct {
    logic        is_inst;
    logic        is_wr;
    logic [31:0] data;
    logic [31:0] hold;
    logic        hchk;
    int          lat;
    int          wec;
    int          oec;
    logic [17:0] saddr;
    logic [3:0]  be;
    logic        dqoe;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  vec_t v0 [12];
  vec_t v1 [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.is_inst = (v.kind == 0);
    e.is_wr   = (v.kind >= 2);
    e.data    = v.data;
    e.hold    = v.hold;
    e.hchk    = v.hchk;
    e.lat     = v.lat;
    e.wec     = v.wec;
    e.oec     = v.oec;
    e.saddr   = v.saddr;
    e.be      = e.is_wr ? ~v.bwe : 4'h0;
    e.dqoe    = e.is_wr;
    e.wdata   = v.wdata;
    sbq.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    case (v.kind)
      0: begin inst_addr = v.addr; inst_read = 1'b1; end
      1: begin data_addr = v.addr; data_read = 1'b1; end
      2: begin data_addr = v.addr; data_wdata = v.wdata; bwe = v.bwe; data_write = 1'b1; end
      default: begin
        data_addr = v.addr; data_wdata = v.wdata; bwe = v.bwe;
        data_read = 1'b1; data_write = 1'b1;
      end
    endcase
    push_exp(v);
  endtask

  // Watches the observed DUT until every queued access has answered, then
  // checks that no further ready pulse follows.
  task automatic engine(input int budget);
    int          wec = 0, oec = 0, extra = 0;
    logic        seen = 1'b0;
    logic [17:0] a = '0;
    logic [3:0]  be = '0;
    logic        dqoe = 1'b0;
    logic [31:0] dqo = '0;
    exp_t        e;
    for (int c = 0; c < budget && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (!o_we_n) wec++;
      if (!o_oe_n) oec++;
      if (!seen && (!o_we_n || !o_oe_n)) begin
        seen = 1'b1; a = o_addr; be = o_be_n; dqoe = o_dq_oe; dqo = o_dq_o;
      end
      if (o_inst_ready || o_data_ready) begin
        e = sbq.pop_front();
        chk("ready_port", {30'b0, o_inst_ready, o_data_ready}, e.is_inst ? 32'd2 : 32'd1);
        chk("latency",    c,         e.lat);
        chk("we_cycles",  wec,       e.wec);
        chk("oe_cycles",  oec,       e.oec);
        chk("sram_addr",  {14'b0, a}, {14'b0, e.saddr});
        chk("be_n",       {28'b0, be}, {28'b0, e.be});
        chk("dq_oe",      {31'b0, dqoe}, {31'b0, e.dqoe});
        if (e.is_wr) chk("dq_o", dqo, e.wdata);
        if (e.is_inst) begin
          chk("inst", o_inst, e.data);
          if (e.hchk) chk("rdata_hold", o_rdata, e.hold);
        end else if (e.is_wr) begin
          if (e.hchk) chk("rdata_hold", o_rdata, e.hold);
        end else begin
          chk("data_rdata", o_rdata, e.data);
        end
        wec = 0; oec = 0; seen = 1'b0;
        @(posedge clk); #1;
        if (e.is_inst) inst_read = 1'b0;
        else begin data_read = 1'b0; data_write = 1'b0; end
      end
    end
    if (sbq.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d access(es) still pending, expected 0", sbq.size());
      sbq.delete();
    end
    inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_inst_ready || o_data_ready) extra++;
    end
    chk("extra_ready", extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit          found;
    int          extra;
    vec_t        vf;
    exp_t        ed, ei;

    for (int i = 0; i < 1024; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
    mem0[10'h010] = 32'h8C220004; mem1[10'h010] = 32'h8C220004;
    mem0[10'h041] = 32'h11223344; mem1[10'h041] = 32'h11223344;
    mem0[10'h020] = 32'hDEADBEEF; mem1[10'h020] = 32'hDEADBEEF;

    //            kind addr          wdata         bwe      data          hold          saddr   lat wec oec hchk
    v0[0]  = '{0, 32'h0000_0040, 32'h0,        4'b0000, 32'h8C220004, 32'h0,        18'h10, 3, 0, 2, 1'b1};
    v0[1]  = '{2, 32'h0000_0104, 32'hAABBCCDD, 4'b0100, 32'h0,        32'h0,        18'h41, 5, 2, 0, 1'b1};
    v0[2]  = '{1, 32'h0000_0104, 32'h0,        4'b0000, 32'h11BB3344, 32'h0,        18'h41, 3, 0, 2, 1'b1};
    v0[3]  = '{1, 32'hFFF0_0083, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h0,        18'h20, 3, 0, 2, 1'b1};
    v0[4]  = '{2, 32'h0000_0080, 32'h55555555, 4'b0000, 32'h0,        32'hDEADBEEF, 18'h20, 5, 2, 0, 1'b1};
    v0[5]  = '{1, 32'h0000_0080, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h0,        18'h20, 3, 0, 2, 1'b1};
    v0[6]  = '{2, 32'h0000_0200, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hDEADBEEF, 18'h80, 5, 2, 0, 1'b1};
    v0[7]  = '{1, 32'h0000_0200, 32'h0,        4'b0000, 32'hCAFEF00D, 32'h0,        18'h80, 3, 0, 2, 1'b1};
    v0[8]  = '{3, 32'h0000_0204, 32'h12345678, 4'b1111, 32'h0,        32'hCAFEF00D, 18'h81, 5, 2, 0, 1'b1};
    v0[9]  = '{1, 32'h0000_0204, 32'h0,        4'b0000, 32'h12345678, 32'h0,        18'h81, 3, 0, 2, 1'b1};
    v0[10] = '{2, 32'h0000_0104, 32'hA0B0C0D0, 4'b1001, 32'h0,        32'h12345678, 18'h41, 5, 2, 0, 1'b1};
    v0[11] = '{1, 32'h0000_0104, 32'h0,        4'b0000, 32'hA0BB33D0, 32'h0,        18'h41, 3, 0, 2, 1'b1};

    v1[0]  = '{0, 32'h0000_0040, 32'h0,        4'b0000, 32'h8C220004, 32'h0,        18'h10, 2, 0, 1, 1'b0};
    v1[1]  = '{2, 32'h0000_0300, 32'h0BADF00D, 4'b1111, 32'h0,        32'h0,        18'hC0, 6, 3, 0, 1'b0};
    v1[2]  = '{1, 32'h0000_0300, 32'h0,        4'b0000, 32'h0BADF00D, 32'h0,        18'hC0, 2, 0, 1, 1'b0};

    // Reset values while rst is held.
    #12;
    chk("rst_ce_n",   {31'b0, o_ce_n},  32'd1);
    chk("rst_oe_n",   {31'b0, o_oe_n},  32'd1);
    chk("rst_we_n",   {31'b0, o_we_n},  32'd1);
    chk("rst_be_n",   {28'b0, o_be_n},  32'hF);
    chk("rst_dq_oe",  {31'b0, o_dq_oe}, 32'd0);
    chk("rst_addr",   {14'b0, o_addr},  32'd0);
    chk("rst_dq_o",   o_dq_o,           32'd0);
    chk("rst_inst",   o_inst,           32'd0);
    chk("rst_rdata",  o_rdata,          32'd0);
    chk("rst_ready",  {30'b0, o_inst_ready, o_data_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(v0[i]);
      engine(40);
    end

    // Contention: data read first, then the fetch one idle cycle later.
    @(posedge clk); #1;
    inst_addr = 32'h0000_0040; inst_read = 1'b1;
    data_addr = 32'h0000_0104; data_read = 1'b1;
    ed = '{1'b0, 1'b0, 32'hA0BB33D0, 32'h0, 1'b0, 3, 0, 2, 18'h41, 4'h0, 1'b0, 32'h0};
    ei = '{1'b1, 1'b0, 32'h8C220004, 32'hA0BB33D0, 1'b1, 7, 0, 2, 18'h10, 4'h0, 1'b0, 32'h0};
    sbq.push_back(ed);
    sbq.push_back(ei);
    engine(40);

    // Reset during the write pulse: pins go idle without a clock edge.
    @(posedge clk); #1;
    data_addr = 32'h0000_0300; data_wdata = 32'h0000_0001; bwe = 4'b1111; data_write = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (!o_we_n) found = 1'b1;
    end
    chk("reach_wr_pulse", {31'b0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we_n",  {31'b0, o_we_n},  32'd1);
    chk("midrst_ce_n",  {31'b0, o_ce_n},  32'd1);
    chk("midrst_dq_oe", {31'b0, o_dq_oe}, 32'd0);
    data_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_inst_ready || o_data_ready) extra++;
    end
    chk("midrst_no_ready", extra, 0);
    chk("midrst_inst",  o_inst,  32'd0);
    chk("midrst_rdata", o_rdata, 32'd0);
    vf = v0[0];
    drive(vf);
    engine(40);

    // Second instance: RD_WAIT=1, WR_WAIT=3.
    repeat (20) @(posedge clk);
    use1 = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(v1[i]);
      engine(40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
